// File: rtl/div_arbiter_if.sv
// Requester request/response channels plus the shared divider handshake.
// slave = arbiter view, master = requesters and divider view.
interface div_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ack;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_error;
  logic                  rsp_timeout;
  logic                  div_start;
  logic                  div_abort;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic                  div_done;
  logic                  div_error;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ack,
           div_done, div_error, div_quotient, div_remainder,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
           div_start, div_abort, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ack,
           div_done, div_error, div_quotient, div_remainder,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
           div_start, div_abort, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one divider: accept -> START (1 cycle) -> WAIT -> RESP held until owner ack.
// Requesters hold req_valid while busy; divide-by-zero skips the divider and responds the cycle after accept.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  div_arbiter_if.slave  bus,
  output logic          busy_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             err_q;
  logic             tmo_q;
  logic             start_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] dvd_sel;
  logic [WIDTH-1:0] dvs_sel;
  logic             expire;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[IW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    dvd_sel = '0;
    dvs_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win_idx) begin
        dvd_sel = bus.req_dividend[i*WIDTH +: WIDTH];
        dvs_sel = bus.req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  assign cnt_d  = cnt_q + 1'b1;
  // Abort fires in the last WAIT cycle, unless the divider finishes in that same cycle.
  assign expire = (state_q == WAIT) && !bus.div_error && !bus.div_done && (cnt_d == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= win_idx;
            dvd_q   <= dvd_sel;
            dvs_q   <= dvs_sel;
            quo_q   <= '0;
            rem_q   <= '0;
            tmo_q   <= 1'b0;
            if (dvs_sel == '0) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              err_q   <= 1'b0;
              start_q <= 1'b1;
              state_q <= START;
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.div_error) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (bus.div_done) begin
            quo_q   <= bus.div_quotient;
            rem_q   <= bus.div_remainder;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_d;
            if (expire) begin
              err_q   <= 1'b1;
              tmo_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ack[owner_q]) begin
            ptr_q   <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // req_ready is gated by reset so nothing looks acceptable while reset is held.
  assign bus.req_ready     = (rst_ni && state_q == IDLE && win_vld)
                             ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign bus.rsp_valid     = (state_q == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign bus.rsp_quotient  = quo_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_error     = err_q;
  assign bus.rsp_timeout   = tmo_q;
  assign bus.div_start     = start_q;
  assign bus.div_abort     = expire;
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign busy_o            = (state_q != IDLE);
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: divider model, grant-time scoreboard, vector table and reset/round-robin sequences.
module tb_div_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  div_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         owner;
    logic [7:0] q;
    logic [7:0] r;
    bit         err;
    bit         tmo;
  } sb_t;
  sb_t sb[$];
  int  grant_q[$];

  logic [7:0] exp_q_a [NREQ];
  logic [7:0] exp_r_a [NREQ];
  bit         exp_err_a [NREQ];
  bit         exp_tmo_a [NREQ];

  // Divider model: mode 0 = done after lat, 1 = error+done after lat, 2 = never finishes.
  int mdl_mode = 0;
  int mdl_lat  = 2;
  int mdl_cnt  = 0;
  bit mdl_run  = 1'b0;
  int done_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mdl_run = 1'b0;
      bus.div_done = 1'b0;
      bus.div_error = 1'b0;
      bus.div_quotient = '0;
      bus.div_remainder = '0;
    end else if (bus.div_start) begin
      mdl_run = 1'b1;
      mdl_cnt = 0;
      bus.div_done = 1'b0;
      bus.div_error = 1'b0;
    end else if (mdl_run) begin
      mdl_cnt++;
      if (mdl_mode != 2 && mdl_cnt == mdl_lat) begin
        mdl_run  = 1'b0;
        done_cyc = cyc;
        bus.div_done = 1'b1;
        if (mdl_mode == 1) begin
          bus.div_error = 1'b1;
          bus.div_quotient = 8'hA5;
          bus.div_remainder = 8'h5A;
        end else begin
          bus.div_quotient = bus.div_dividend / bus.div_divisor;
          bus.div_remainder = bus.div_dividend % bus.div_divisor;
        end
      end
    end
  end

  // Monitor and responder, sampling on the falling edge.
  int start_cnt = 0, abort_cnt = 0, start_cyc = 0, done_cnt = 0;
  int ack_delay = 0, rsp_seen = 0, rsp_first_cyc = 0;
  bit hold_ok = 1'b1;
  logic [NREQ+2*WIDTH+1:0] snap, cur;

  always @(negedge clk) begin
    if (bus.div_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.div_abort) abort_cnt++;
    if (rst_n && !busy && ((bus.req_valid & bus.req_ready) != '0)) begin
      int g;
      g = 0;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      chk("grant_onehot", $countones(bus.req_ready), 1);
      grant_q.push_back(g);
      sb.push_back('{g, exp_q_a[g], exp_r_a[g], exp_err_a[g], exp_tmo_a[g]});
    end
    cur = {bus.rsp_valid, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_error, bus.rsp_timeout};
    if (bus.rsp_valid != '0) begin
      if (rsp_seen == 0) begin
        snap = cur;
        rsp_first_cyc = cyc;
        hold_ok = 1'b1;
      end else if (cur !== snap) begin
        hold_ok = 1'b0;
      end
      rsp_seen++;
      if (rsp_seen - 1 == ack_delay) begin
        bus.rsp_ack = bus.rsp_valid;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk($sformatf("rsp_valid_o%0d", e.owner), bus.rsp_valid, 32'(1) << e.owner);
          chk($sformatf("rsp_quot_o%0d", e.owner), bus.rsp_quotient, e.q);
          chk($sformatf("rsp_rem_o%0d", e.owner), bus.rsp_remainder, e.r);
          chk($sformatf("rsp_err_o%0d", e.owner), {bus.rsp_error, bus.rsp_timeout}, {e.err, e.tmo});
          chk($sformatf("rsp_hold_o%0d", e.owner), hold_ok, 1);
        end
        done_cnt++;
      end else if (rsp_seen == 1 && ack_delay >= 2) begin
        // ack on a non-owner index must be ignored
        bus.rsp_ack = {bus.rsp_valid[NREQ-2:0], bus.rsp_valid[NREQ-1]};
      end else begin
        bus.rsp_ack = '0;
      end
    end else begin
      rsp_seen = 0;
      bus.rsp_ack = '0;
    end
  end

  task automatic wait_grant(input int n, output int g);
    g = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (grant_q.size() > n) begin
        g = grant_q[n];
        return;
      end
    end
    chk("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 400; k++) begin
      if (done_cnt >= target) return;
      @(posedge clk); #1;
    end
    chk("rsp_wait_expired", done_cnt, target);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_ready_valid_busy"}, {bus.req_ready, bus.rsp_valid, busy}, 0);
    chk({nm, "_div"}, {bus.div_start, bus.div_abort, bus.div_dividend, bus.div_divisor}, 0);
    chk({nm, "_rsp"}, {bus.rsp_quotient, bus.rsp_remainder, bus.rsp_error, bus.rsp_timeout}, 0);
  endtask

  typedef struct {
    int         owner;
    logic [7:0] a;
    logic [7:0] b;
    int         mode;
    int         lat;
    int         ackd;
    logic [7:0] eq;
    logic [7:0] er;
    bit         eerr;
    bit         etmo;
  } vec_t;

  initial begin
    vec_t vt [8];
    int   g, base, s0, a0, d0;
    int   rr2 [3];

    vt[0] = '{0, 8'd100, 8'd7,  0, 20, 5, 8'd14,  8'd2,  1'b0, 1'b0};
    vt[1] = '{2, 8'd55,  8'd0,  0, 1,  0, 8'd0,   8'd0,  1'b1, 1'b0};
    vt[2] = '{1, 8'd200, 8'd13, 1, 3,  1, 8'd0,   8'd0,  1'b1, 1'b0};
    vt[3] = '{3, 8'd77,  8'd9,  2, 1,  0, 8'd0,   8'd0,  1'b1, 1'b1};
    vt[4] = '{1, 8'd255, 8'd16, 0, 5,  2, 8'd15,  8'd15, 1'b0, 1'b0};
    vt[5] = '{3, 8'd9,   8'd10, 0, 1,  0, 8'd0,   8'd9,  1'b0, 1'b0};
    vt[6] = '{2, 8'd0,   8'd5,  0, 2,  0, 8'd0,   8'd0,  1'b0, 1'b0};
    vt[7] = '{0, 8'd255, 8'd1,  0, 4,  3, 8'd255, 8'd0,  1'b0, 1'b0};
    rr2 = '{0, 3, 0};

    // All four requesters valid from reset: 20/3, 30/3, 40/3, 50/3.
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    exp_q_a = '{8'd6, 8'd10, 8'd13, 8'd16};
    exp_r_a = '{8'd2, 8'd0,  8'd1,  8'd2};
    exp_err_a = '{default: 1'b0};
    exp_tmo_a = '{default: 1'b0};
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dividend[i*WIDTH +: WIDTH] = 8'(20 + 10 * i);
      bus.req_divisor[i*WIDTH +: WIDTH]  = 8'd3;
    end
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("por");
    rst_n = 1'b1;

    for (int n = 0; n < 4; n++) begin
      wait_grant(n, g);
      chk($sformatf("rr_order_%0d", n), g, n);
      if (g >= 0) bus.req_valid[g] = 1'b0;
      wait_rsp(n + 1);
    end

    // 0 and 3 together, 0 stays valid: 0 must wait behind 3 for its second grant.
    exp_q_a[0] = 8'd3;  exp_r_a[0] = 8'd2;
    exp_q_a[3] = 8'd28; exp_r_a[3] = 8'd4;
    bus.req_dividend[0*WIDTH +: WIDTH] = 8'd17;  bus.req_divisor[0*WIDTH +: WIDTH] = 8'd5;
    bus.req_dividend[3*WIDTH +: WIDTH] = 8'd200; bus.req_divisor[3*WIDTH +: WIDTH] = 8'd7;
    base = grant_q.size();
    d0 = done_cnt;
    bus.req_valid = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      wait_grant(base + n, g);
      chk($sformatf("rr2_order_%0d", n), g, rr2[n]);
      if (n == 1) bus.req_valid[3] = 1'b0;
      if (n == 2) bus.req_valid[0] = 1'b0;
      wait_rsp(d0 + n + 1);
    end

    for (int v = 0; v < 8; v++) begin
      mdl_mode  = vt[v].mode;
      mdl_lat   = vt[v].lat;
      ack_delay = vt[v].ackd;
      exp_q_a[vt[v].owner]   = vt[v].eq;
      exp_r_a[vt[v].owner]   = vt[v].er;
      exp_err_a[vt[v].owner] = vt[v].eerr;
      exp_tmo_a[vt[v].owner] = vt[v].etmo;
      s0 = start_cnt; a0 = abort_cnt; d0 = done_cnt;
      base = grant_q.size();
      @(posedge clk); #1;
      bus.req_dividend[vt[v].owner*WIDTH +: WIDTH] = vt[v].a;
      bus.req_divisor[vt[v].owner*WIDTH +: WIDTH]  = vt[v].b;
      bus.req_valid[vt[v].owner] = 1'b1;
      wait_grant(base, g);
      chk($sformatf("v%0d_owner", v), g, vt[v].owner);
      bus.req_valid[vt[v].owner] = 1'b0;
      @(negedge clk);
      if (vt[v].b != 8'd0) begin
        chk($sformatf("v%0d_start", v), bus.div_start, 1);
        chk($sformatf("v%0d_ops", v), {bus.div_dividend, bus.div_divisor}, {vt[v].a, vt[v].b});
      end else begin
        chk($sformatf("v%0d_dz_rsp", v), {bus.div_start, bus.rsp_valid}, {1'b0, 4'(1 << vt[v].owner)});
      end
      wait_rsp(d0 + 1);
      chk($sformatf("v%0d_starts", v), start_cnt - s0, (vt[v].b != 8'd0) ? 1 : 0);
      chk($sformatf("v%0d_aborts", v), abort_cnt - a0, (vt[v].mode == 2 && vt[v].b != 8'd0) ? 1 : 0);
      if (vt[v].b != 8'd0 && vt[v].mode == 2)
        chk($sformatf("v%0d_wd_lat", v), rsp_first_cyc - start_cyc, TIMEOUT + 1);
      else if (vt[v].b != 8'd0)
        chk($sformatf("v%0d_done_lat", v), rsp_first_cyc - done_cyc, 1);
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), {busy, bus.rsp_valid}, 0);
    end

    // Reset while requester 1 (60/7) waits on a divider that never finishes.
    mdl_mode = 2;
    ack_delay = 0;
    exp_q_a[1] = 8'd8; exp_r_a[1] = 8'd4; exp_err_a[1] = 1'b0; exp_tmo_a[1] = 1'b0;
    base = grant_q.size();
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.req_dividend[1*WIDTH +: WIDTH] = 8'd60;
    bus.req_divisor[1*WIDTH +: WIDTH]  = 8'd7;
    bus.req_valid[1] = 1'b1;
    wait_grant(base, g);
    chk("rst_first_owner", g, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_rst");
    sb.delete();
    mdl_mode = 0;
    mdl_lat = 10;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = grant_q.size();
    wait_grant(base, g);
    chk("rst_regrant_owner", g, 1);
    bus.req_valid[1] = 1'b0;
    wait_rsp(d0 + 1);
    chk("rst_rsp_count", done_cnt - d0, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=%0d cycles required=completion", cyc);
    $fatal(1, "time limit");
  end
endmodule
